// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage branch flush, data-memory freeze.
// Optional saturating performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W          = 5,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mRead,
  input  logic             mem_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state_o,
  output logic             mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [31:0]      wait_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MWAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LD_RELOAD  = CNT_W'(LOAD_STALL_CYC - 1);
  localparam logic             LD_MULTI   = (LOAD_STALL_CYC > 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ld_cnt, ld_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_nxt;
  logic             err_nxt;
  logic             hz, freeze, resume_ld;

  assign hz = ex_mRead && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign freeze = dmem_req && !dmem_ready;
  // A load-use stall interrupted by a freeze keeps its remaining count and resumes on exit.
  assign resume_ld = (state == ST_LDSTALL) || ((state == ST_MWAIT) && (ld_cnt != '0));
  assign state_o = 2'(state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      ld_cnt  <= '0;
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      ld_cnt  <= ld_nxt;
      tmo_cnt <= tmo_nxt;
      mem_err <= err_nxt;
    end
  end

  // Next state and enable/flush decode; priority is reset > freeze > branch > load-use.
  always_comb begin
    state_nxt   = state;
    ld_nxt      = ld_cnt;
    tmo_nxt     = tmo_cnt;
    err_nxt     = mem_err;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = ST_RUN;
      ld_nxt      = '0;
      tmo_nxt     = '0;
      err_nxt     = 1'b0;
    end else if (freeze) begin
      state_nxt = ST_MWAIT;
      tmo_nxt   = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + CNT_W'(1);
      if (tmo_nxt >= TMO_LIM) err_nxt = 1'b1;
    end else begin
      tmo_nxt = '0;
      if (mem_br_taken) begin
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        state_nxt   = ST_RUN;
        ld_nxt      = '0;
      end else if (resume_ld || hz) begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        if (resume_ld) begin
          ld_nxt    = (ld_cnt > CNT_W'(1)) ? ld_cnt - CNT_W'(1) : '0;
          state_nxt = (ld_cnt > CNT_W'(1)) ? ST_LDSTALL : ST_RUN;
        end else if (LD_MULTI) begin
          ld_nxt    = LD_RELOAD;
          state_nxt = ST_LDSTALL;
        end else begin
          state_nxt = ST_RUN;
        end
      end else begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        state_nxt = ST_RUN;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic stall_ev, flush_ev, wait_ev;

  assign wait_ev  = freeze;
  assign flush_ev = !freeze && mem_br_taken;
  assign stall_ev = !freeze && !mem_br_taken && (resume_ld || hz);

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      if (wait_ev && (wait_cnt != '1))   wait_cnt  <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule
